register_file: RTL

REGISTER_FILE -- requirements
Module: register_file

---
 rtl/register_file_pkg.sv | 16 +
 rtl/register_file_dump.sv | 64 ++++++
 rtl/register_file.sv | 69 ++++++
 3 files changed

// File: rtl/register_file_pkg.sv
// Shared sizing and dump-state encoding for the register file.
// Imported by the register array top and its dump sequencer.
package register_file_pkg;

    localparam int REG_COUNT   = 32;
    localparam int DATA_WIDTH  = 32;
    localparam int INDEX_WIDTH = 5;

    localparam logic [INDEX_WIDTH-1:0] LAST_INDEX = INDEX_WIDTH'(REG_COUNT - 1);

    typedef enum logic {
        IDLE = 1'b0,
        DUMP = 1'b1
    } dump_state_t;

endpackage

// File: rtl/register_file_dump.sv
// Dump sequencer: walks indices 0..31 under a valid/ready handshake.
// Pulses done the cycle after the last index is accepted.
module register_file_dump
    import register_file_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   dump_start,
    input  logic                   dump_ready,
    output logic                   dump_valid,
    output logic [INDEX_WIDTH-1:0] dump_index,
    output logic                   dump_done
);

    dump_state_t            state;
    dump_state_t            state_next;
    logic [INDEX_WIDTH-1:0] index_next;
    logic                   done_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            dump_index <= '0;
            dump_done  <= 1'b0;
        end else begin
            state      <= state_next;
            dump_index <= index_next;
            dump_done  <= done_next;
        end
    end

    // Index is parked at zero whenever the sequencer is idle.
    always_comb begin
        state_next = state;
        index_next = dump_index;
        done_next  = 1'b0;
        unique case (state)
            IDLE: begin
                if (dump_start) begin
                    state_next = DUMP;
                    index_next = '0;
                end
            end
            DUMP: begin
                if (dump_ready) begin
                    if (dump_index == LAST_INDEX) begin
                        state_next = IDLE;
                        index_next = '0;
                        done_next  = 1'b1;
                    end else begin
                        index_next = dump_index + 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                index_next = '0;
            end
        endcase
    end

    assign dump_valid = (state == DUMP);

endmodule

// File: rtl/register_file.sv
// 32x32 register file: one write port, two registered read ports with
// write bypass, and a handshaked sequential dump of all registers.
module register_file
    import register_file_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic [INDEX_WIDTH-1:0] write_address,
    input  logic [DATA_WIDTH-1:0]  write_data,
    input  logic                   write_enable,
    input  logic [INDEX_WIDTH-1:0] read_reg_0,
    input  logic [INDEX_WIDTH-1:0] read_reg_1,
    input  logic                   read_enable,
    output logic [DATA_WIDTH-1:0]  read_data_0,
    output logic [DATA_WIDTH-1:0]  read_data_1,
    output logic                   read_valid,
    input  logic                   dump_start,
    output logic                   dump_valid,
    input  logic                   dump_ready,
    output logic [INDEX_WIDTH-1:0] dump_index,
    output logic [DATA_WIDTH-1:0]  dump_data,
    output logic                   dump_done
);

    logic [DATA_WIDTH-1:0] regs [REG_COUNT];
    logic                  hit_0;
    logic                  hit_1;

    assign hit_0 = write_enable && (read_reg_0 == write_address);
    assign hit_1 = write_enable && (read_reg_1 == write_address);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs[i] <= '0;
            end
        end else if (write_enable) begin
            regs[write_address] <= write_data;
        end
    end

    // Same-cycle write to a read index forwards the new value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            read_data_0 <= '0;
            read_data_1 <= '0;
            read_valid  <= 1'b0;
        end else begin
            read_valid <= read_enable;
            if (read_enable) begin
                read_data_0 <= hit_0 ? write_data : regs[read_reg_0];
                read_data_1 <= hit_1 ? write_data : regs[read_reg_1];
            end
        end
    end

    register_file_dump u_dump (
        .clk        (clk),
        .rst        (rst),
        .dump_start (dump_start),
        .dump_ready (dump_ready),
        .dump_valid (dump_valid),
        .dump_index (dump_index),
        .dump_done  (dump_done)
    );

    assign dump_data = regs[dump_index];

endmodule
